hub75_bcm: RTL and testbench
============================

// Module: hub75_bcm
// PURPOSE
//  Binary-code-modulation engine for one HUB75 row. Accepts a row from the
//  row scan controller (bcm_row/bcm_go/bcm_rdy), shifts each bit plane into the
//  panel through the pixel shifter, then latches it and unblanks the panel for
//  a time proportional to 2^plane. Plane p+1 shifts while plane p is displayed,
//  and the next row's first shift overlaps the last plane's display.
// PARAMETERS
//  N_ROWS      32  rows addressed per panel half; LOG_N_ROWS = $clog2(N_ROWS)
//  N_PLANES    8   bit planes per colour; LOG_N_PLANES = $clog2(N_PLANES)
//  TW          8+N_PLANES  display timer width (derived, not overridden)
// PORTS
//  clk            in   1             clock
//  rst            in   1             synchronous reset, active-high
//  bcm_row        in   LOG_N_ROWS    row to paint, sampled when bcm_go & bcm_rdy
//  bcm_go         in   1             paint request, single-cycle pulse
//  bcm_rdy        out  1             engine can accept bcm_go this cycle
//  shift_plane    out  LOG_N_PLANES  plane the shifter must output
//  shift_go       out  1             start shifting shift_plane, 1-cycle pulse
//  shift_rdy      in   1             shifter idle / previous shift finished
//  phy_addr       out  LOG_N_ROWS    panel row address (A..E)
//  phy_le         out  1             panel latch strobe
//  phy_blank      out  1             panel output disable (1 = dark)
//  cfg_lsb_len    in   8             display cycles of plane 0 (static while busy)
// BEHAVIOUR
//  Reset: state IDLE, timer 0, plane 0, phy_addr 0, phy_le 0, shift_go 0,
//   phy_blank 1, bcm_rdy 1. Reset mid-row aborts immediately; no drain.
//  States (registered; outputs decoded from state/timer):
//   IDLE  : bcm_rdy=1. On bcm_go: row_r<=bcm_row, plane<=0 -> SHIFT.
//   SHIFT : shift_go=1, shift_plane=plane, exactly 1 cycle -> WAIT.
//   WAIT  : stay until shift_rdy=1 AND timer==0 -> BLANK.
//   BLANK : phy_blank=1, 1 cycle -> LATCH.
//   LATCH : phy_le=1, phy_blank=1, phy_addr<=row_r,
//           timer<=cfg_lsb_len<<plane (zero-extended to TW).
//           plane==N_PLANES-1 ? -> DRAIN : plane<=plane+1, -> SHIFT.
//   DRAIN : bcm_rdy=1. bcm_go: row_r<=bcm_row, plane<=0 -> SHIFT (timer keeps
//           running). Else timer==0 -> IDLE.
//  shift_rdy is sampled only in WAIT; shift_go, phy_le never asserted in same cycle.
//  Timer: decrements by 1 each cycle while nonzero; loaded only in LATCH.
//   phy_blank = (timer==0) | state in {BLANK,LATCH}. Plane p is lit exactly
//   cfg_lsb_len*2^p consecutive cycles, starting the cycle after LATCH.
//  cfg_lsb_len=0: planes latched but never lit; sequencing otherwise unchanged.
//  phy_addr changes only in LATCH (always while blanked); holds between rows.
//  Latency: bcm_go in IDLE -> shift_go 1 cycle later. shift_rdy already high
//   and timer 0 -> first phy_le 3 cycles after shift_go.
//  bcm_go while bcm_rdy=0 is ignored (protocol violation, no state change).
//  bcm_rdy never high in SHIFT/WAIT/BLANK/LATCH; the row controller may swap
//   the front buffer on bcm_go because the last plane was already shifted.
// TESTING
//  1 Reset -> phy_blank=1, bcm_rdy=1, phy_le=0, shift_go=0, phy_addr=0.
//  2 N_PLANES=3, cfg_lsb_len=4, shift_rdy tied 1, bcm_go row=5 -> shift_go for
//    planes 0,1,2; phy_addr=5 at first phy_le; lit windows 4,8,16 cycles; IDLE
//    after last window expires.
//  3 Shifter stalls shift_rdy=0 for 20 cycles on plane 1 -> no latch until
//    shift_rdy=1; blank stays 1 after plane-0 window; plane-1 window still 8.
//  4 bcm_go row=6 during DRAIN of row 5 -> shift_go plane 0 next cycle; row-6
//    phy_le held off until row-5 plane-2 window ends; phy_addr 5->6 only at LE.
//  5 cfg_lsb_len=0 -> phy_le pulses per plane, phy_blank constantly 1.
//  6 rst asserted in WAIT mid-row -> next cycle IDLE, blank=1, bcm_rdy=1; a
//    new bcm_go restarts at plane 0.

Source files
------------

// File: rtl/hub75_bcm.sv
// hub75_bcm: binary-code-modulation sequencer for one HUB75 row.
// Each bit plane is shifted into the panel by the external pixel shifter,
// then latched and lit for cfg_lsb_len << plane cycles. The next plane (or
// the first plane of the next row) shifts while the current plane is lit.
module hub75_bcm #(
    parameter  int N_ROWS       = 32,
    parameter  int N_PLANES     = 8,
    localparam int LOG_N_ROWS   = $clog2(N_ROWS),
    localparam int LOG_N_PLANES = $clog2(N_PLANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LOG_N_ROWS-1:0]   bcm_row,
    input  logic                    bcm_go,
    output logic                    bcm_rdy,
    output logic [LOG_N_PLANES-1:0] shift_plane,
    output logic                    shift_go,
    input  logic                    shift_rdy,
    output logic [LOG_N_ROWS-1:0]   phy_addr,
    output logic                    phy_le,
    output logic                    phy_blank,
    input  logic [7:0]              cfg_lsb_len
);

    localparam int TW = 8 + N_PLANES;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        BLANK,
        LATCH,
        DRAIN
    } state_t;

    state_t                  state;
    logic [TW-1:0]           timer;
    logic [LOG_N_PLANES-1:0] plane;
    logic [LOG_N_ROWS-1:0]   row_r;
    logic                    timer_zero;
    logic                    last_plane;
    logic [TW-1:0]           load_val;

    assign timer_zero  = (timer == '0);
    assign last_plane  = (plane == LOG_N_PLANES'(N_PLANES - 1));
    assign load_val    = {{N_PLANES{1'b0}}, cfg_lsb_len} << plane;

    assign bcm_rdy     = (state == IDLE) || (state == DRAIN);
    assign shift_go    = (state == SHIFT);
    assign shift_plane = plane;
    assign phy_le      = (state == LATCH);
    assign phy_blank   = timer_zero || (state == BLANK) || (state == LATCH);

    // Plane/row sequencer; the row address is taken on entry to LATCH so it
    // is already valid during the latch strobe and only moves while blanked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            plane    <= '0;
            row_r    <= '0;
            phy_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bcm_go) begin
                        row_r <= bcm_row;
                        plane <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (shift_rdy && timer_zero) begin
                        state <= BLANK;
                    end
                end
                BLANK: begin
                    phy_addr <= row_r;
                    state    <= LATCH;
                end
                LATCH: begin
                    if (last_plane) begin
                        state <= DRAIN;
                    end else begin
                        plane <= plane + 1'b1;
                        state <= SHIFT;
                    end
                end
                DRAIN: begin
                    if (bcm_go) begin
                        row_r <= bcm_row;
                        plane <= '0;
                        state <= SHIFT;
                    end else if (timer_zero) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Display timer: loaded with the plane weight at latch time, then counts
    // down to zero; the panel is lit exactly while it is nonzero.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (state == LATCH) begin
            timer <= load_val;
        end else if (!timer_zero) begin
            timer <= timer - 1'b1;
        end
    end

endmodule

// File: tb/tb_hub75_bcm.sv
// tb_hub75_bcm: self-checking bench for hub75_bcm with three bit planes.
// Directed table of single-row paints, hand-written overlap and reset
// sequences, and randomized multi-row runs against an event-level model.
module tb_hub75_bcm;

    localparam int NP   = 3;
    localparam int NR   = 32;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] bcm_row = '0;
    logic       bcm_go = 1'b0;
    logic       bcm_rdy;
    logic [1:0] shift_plane;
    logic       shift_go;
    logic       shift_rdy = 1'b1;
    logic [4:0] phy_addr;
    logic       phy_le;
    logic       phy_blank;
    logic [7:0] cfg_lsb_len = 8'd0;

    int errors = 0;
    int checks = 0;

    // Stimulus and captured response, indexed by cycle since the last reset
    logic       in_go    [MAXC];
    logic [4:0] in_row   [MAXC];
    logic       in_srdy  [MAXC];
    logic       out_go   [MAXC];
    logic [1:0] out_plane[MAXC];
    logic       out_le   [MAXC];
    logic [4:0] out_addr [MAXC];
    logic       out_blank[MAXC];
    logic       out_rdy  [MAXC];

    // Reference-model expectations for the randomized runs
    logic       e_go    [MAXC];
    logic [1:0] e_plane [MAXC];
    logic       e_le    [MAXC];
    logic [4:0] e_addr  [MAXC];
    logic       e_blank [MAXC];
    logic       e_rdy   [MAXC];
    int         le_row  [MAXC];

    typedef struct {
        int cfg;
        int row;
        int stall_from;
        int stall_len;
        int le0, le1, le2;
        int lit0, lit1, lit2;
    } vec_t;

    vec_t vecs[5];

    hub75_bcm #(.N_ROWS(NR), .N_PLANES(NP)) dut (
        .clk         (clk),
        .rst         (rst),
        .bcm_row     (bcm_row),
        .bcm_go      (bcm_go),
        .bcm_rdy     (bcm_rdy),
        .shift_plane (shift_plane),
        .shift_go    (shift_go),
        .shift_rdy   (shift_rdy),
        .phy_addr    (phy_addr),
        .phy_le      (phy_le),
        .phy_blank   (phy_blank),
        .cfg_lsb_len (cfg_lsb_len)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bcm_go    = 1'b0;
        bcm_row   = '0;
        shift_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < MAXC; c++) begin
            in_go[c]   = 1'b0;
            in_row[c]  = '0;
            in_srdy[c] = 1'b1;
        end
    endtask

    // Drive n cycles from the input arrays and capture every output per cycle
    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            bcm_go       = in_go[c];
            bcm_row      = in_row[c];
            shift_rdy    = in_srdy[c];
            out_go[c]    = shift_go;
            out_plane[c] = shift_plane;
            out_le[c]    = phy_le;
            out_addr[c]  = phy_addr;
            out_blank[c] = phy_blank;
            out_rdy[c]   = bcm_rdy;
            tick();
        end
        bcm_go    = 1'b0;
        shift_rdy = 1'b1;
    endtask

    function automatic int pack(input logic go, input logic [1:0] pl, input logic le,
                                input logic [4:0] addr, input logic blank, input logic rdy);
        return (int'(go) << 10) | (go ? (int'(pl) << 8) : 0) | (int'(le) << 7) |
               (int'(addr) << 2) | (int'(blank) << 1) | int'(rdy);
    endfunction

    // Event-level model: each plane latches two cycles after the first cycle
    // where the shifter is ready and the previous window has expired; plane p
    // then stays lit for L*2^p cycles.
    task automatic build_random(input int L, input int nrows, input int stall_pct, output int n);
        int g, s, w, e, z, lp, sfirst, row, cur;
        e  = 0;
        lp = 0;
        for (int c = 0; c < MAXC; c++) begin
            in_go[c]   = 1'b0;
            in_row[c]  = 5'($urandom);
            in_srdy[c] = ($urandom_range(0, 99) >= stall_pct);
            e_go[c]    = 1'b0;
            e_plane[c] = '0;
            e_le[c]    = 1'b0;
            e_blank[c] = 1'b1;
            e_rdy[c]   = 1'b1;
            le_row[c]  = -1;
        end
        g = $urandom_range(0, 3);
        z = 0;
        for (int r = 0; r < nrows; r++) begin
            row       = $urandom_range(0, NR - 1);
            in_go[g]  = 1'b1;
            in_row[g] = 5'(row);
            s         = g + 1;
            sfirst    = s;
            for (int p = 0; p < NP; p++) begin
                e_go[s]    = 1'b1;
                e_plane[s] = 2'(p);
                w = (s + 1 > z) ? s + 1 : z;
                while (w < MAXC - 64 && !in_srdy[w]) w++;
                e         = w + 2;
                e_le[e]   = 1'b1;
                le_row[e] = row;
                lp        = L << p;
                for (int k = 1; k <= lp; k++) e_blank[e + k] = 1'b0;
                z = e + 1 + lp;
                s = e + 1;
            end
            for (int c = sfirst; c <= e; c++) e_rdy[c] = 1'b0;
            if ($urandom_range(0, 1) == 1) in_go[$urandom_range(sfirst, e)] = 1'b1;
            g = e + 1 + $urandom_range(0, lp + 4);
        end
        n   = z + 4;
        cur = 0;
        for (int c = 0; c < n; c++) begin
            if (le_row[c] >= 0) cur = le_row[c];
            e_addr[c] = 5'(cur);
        end
    endtask

    int le_cyc[4];
    int le_addr[4];
    int go_pl[4];
    int go_cyc0;
    int lit[3];
    int nle, ngo, clash, n, lecount;

    // Main test sequence
    initial begin
        vecs[0] = '{4,  5,  0, 0,  4, 11, 22,  4, 8, 16};
        vecs[1] = '{0,  9,  0, 0,  4,  8, 12,  0, 0,  0};
        vecs[2] = '{1,  31, 0, 0,  4,  8, 13,  1, 2,  4};
        vecs[3] = '{4,  17, 5, 20, 4, 27, 38,  4, 8, 16};
        vecs[4] = '{2,  12, 0, 0,  4,  9, 16,  2, 4,  8};

        // Reset values
        do_reset();
        checkOutput("reset_blank", int'(phy_blank), 1);
        checkOutput("reset_rdy",   int'(bcm_rdy),   1);
        checkOutput("reset_le",    int'(phy_le),    0);
        checkOutput("reset_go",    int'(shift_go),  0);
        checkOutput("reset_addr",  int'(phy_addr),  0);

        // Directed single-row paints
        for (int v = 0; v < 5; v++) begin
            do_reset();
            cfg_lsb_len = 8'(vecs[v].cfg);
            clear_inputs();
            in_go[0]  = 1'b1;
            in_row[0] = 5'(vecs[v].row);
            for (int c = vecs[v].stall_from; c < vecs[v].stall_from + vecs[v].stall_len; c++)
                in_srdy[c] = 1'b0;
            applyStimulus(70);
            nle = 0; ngo = 0; clash = 0; go_cyc0 = -1;
            for (int i = 0; i < 3; i++) lit[i] = 0;
            for (int i = 0; i < 4; i++) begin
                le_cyc[i] = -1; le_addr[i] = -1; go_pl[i] = -1;
            end
            for (int c = 0; c < 70; c++) begin
                if (out_go[c]) begin
                    if (ngo == 0) go_cyc0 = c;
                    if (ngo < 4) go_pl[ngo] = int'(out_plane[c]);
                    ngo++;
                end
                if (out_le[c]) begin
                    if (nle < 4) begin
                        le_cyc[nle]  = c;
                        le_addr[nle] = int'(out_addr[c]);
                    end
                    nle++;
                end
                if (!out_blank[c] && nle > 0 && nle <= 3) lit[nle - 1]++;
                if (out_le[c] && out_go[c]) clash++;
            end
            checkOutput($sformatf("v%0d_le_count", v), nle, 3);
            checkOutput($sformatf("v%0d_le0", v), le_cyc[0], vecs[v].le0);
            checkOutput($sformatf("v%0d_le1", v), le_cyc[1], vecs[v].le1);
            checkOutput($sformatf("v%0d_le2", v), le_cyc[2], vecs[v].le2);
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("v%0d_addr%0d", v, i), le_addr[i], vecs[v].row);
            checkOutput($sformatf("v%0d_lit0", v), lit[0], vecs[v].lit0);
            checkOutput($sformatf("v%0d_lit1", v), lit[1], vecs[v].lit1);
            checkOutput($sformatf("v%0d_lit2", v), lit[2], vecs[v].lit2);
            checkOutput($sformatf("v%0d_go_count", v), ngo, 3);
            checkOutput($sformatf("v%0d_go_first", v), go_cyc0, 1);
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("v%0d_go_plane%0d", v, i), go_pl[i], i);
            checkOutput($sformatf("v%0d_le_go_clash", v), clash, 0);
            checkOutput($sformatf("v%0d_end_rdy", v), int'(out_rdy[69]), 1);
            checkOutput($sformatf("v%0d_end_blank", v), int'(out_blank[69]), 1);
        end

        // Next row requested during the last plane's display window
        do_reset();
        cfg_lsb_len = 8'd4;
        clear_inputs();
        in_go[0]   = 1'b1; in_row[0]  = 5'd5;
        in_go[23]  = 1'b1; in_row[23] = 5'd6;
        applyStimulus(60);
        checkOutput("drain_rdy",        int'(out_rdy[23]),   1);
        checkOutput("drain_go",         int'(out_go[24]),    1);
        checkOutput("drain_go_plane",   int'(out_plane[24]), 0);
        checkOutput("drain_busy",       int'(out_rdy[30]),   0);
        checkOutput("drain_lit_late",   int'(out_blank[38]), 0);
        checkOutput("drain_dark",       int'(out_blank[39]), 1);
        lecount = 0;
        for (int c = 23; c < 41; c++) if (out_le[c]) lecount++;
        checkOutput("drain_no_early_le", lecount, 0);
        checkOutput("drain_le",         int'(out_le[41]),    1);
        checkOutput("drain_addr_old",   int'(out_addr[40]),  5);
        checkOutput("drain_addr_new",   int'(out_addr[41]),  6);
        checkOutput("drain_lit_new",    int'(out_blank[42]), 0);

        // Reset while waiting on the shifter for plane 1
        do_reset();
        cfg_lsb_len = 8'd4;
        clear_inputs();
        in_go[0] = 1'b1; in_row[0] = 5'd7;
        for (int c = 5; c < 12; c++) in_srdy[c] = 1'b0;
        applyStimulus(12);
        checkOutput("mid_le0",       int'(out_le[4]),    1);
        checkOutput("mid_go1",       int'(out_go[5]),    1);
        checkOutput("mid_go1_plane", int'(out_plane[5]), 1);
        checkOutput("mid_busy",      int'(out_rdy[11]),  0);
        checkOutput("mid_addr",      int'(out_addr[11]), 7);
        shift_rdy = 1'b0;
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_rdy",   int'(bcm_rdy),   1);
        checkOutput("mid_rst_blank", int'(phy_blank), 1);
        checkOutput("mid_rst_le",    int'(phy_le),    0);
        checkOutput("mid_rst_go",    int'(shift_go),  0);
        checkOutput("mid_rst_addr",  int'(phy_addr),  0);
        rst = 1'b0;
        clear_inputs();
        in_go[0] = 1'b1; in_row[0] = 5'd3;
        applyStimulus(8);
        checkOutput("restart_go",    int'(out_go[1]),    1);
        checkOutput("restart_plane", int'(out_plane[1]), 0);
        checkOutput("restart_le",    int'(out_le[4]),    1);
        checkOutput("restart_addr",  int'(out_addr[4]),  3);

        // Randomized multi-row runs against the event model
        for (int i = 0; i < 7; i++) begin
            int L, rows, spct;
            L    = (i == 6) ? 255 : (i == 0) ? 0 : $urandom_range(0, 24);
            rows = (i == 6) ? 1 : $urandom_range(2, 4);
            spct = $urandom_range(0, 40);
            do_reset();
            cfg_lsb_len = 8'(L);
            build_random(L, rows, spct, n);
            applyStimulus(n);
            for (int c = 0; c < n; c++) begin
                checkOutput($sformatf("rnd%0d_cycle%0d", i, c),
                            pack(out_go[c], out_plane[c], out_le[c], out_addr[c], out_blank[c], out_rdy[c]),
                            pack(e_go[c], e_plane[c], e_le[c], e_addr[c], e_blank[c], e_rdy[c]));
            end
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
